// File: rtl/des_key_sched_ctrl.sv
// des_key_sched_ctrl
// DES key-schedule controller.
//
// A PC-1-permuted 56-bit key is latched when start_i is seen in IDLE. The
// block then presents 16 rotated {C,D} states, one per round, under a
// valid/ready handshake. C and D rotate independently as 28-bit halves.
// After round 16 is accepted, done_o pulses for one cycle. A new start_i is
// accepted in that same cycle.
//
// Configuration macro: DES_KEY_SCHED_DECRYPT_EN
//   defined   -> decrypt_i selects the right-rotating decrypt schedule
//   undefined -> decrypt_i is ignored; every schedule is the encrypt one
module des_key_sched_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        decrypt_i,
    input  logic [55:0] key_i,
    input  logic        subkey_ready_i,
    output logic        subkey_valid_o,
    output logic [55:0] key_o,
    output logic [3:0]  round_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [55:0] key_q,   key_d;
    logic [3:0]  round_q, round_d;
    logic        valid_q, valid_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

`ifdef DES_KEY_SCHED_DECRYPT_EN
    logic        dec_q,   dec_d;
`else
    logic        unused_decrypt_s;
    assign unused_decrypt_s = decrypt_i;
`endif

    // Shift amount for table position idx (0-based): 1 or 2 bits.
    // Positions 0, 1, 8 and 15 rotate by one; all others rotate by two.
    function automatic logic shift_is_two(input logic [3:0] idx);
        logic two;
        case (idx)
            4'd0, 4'd1, 4'd8, 4'd15: two = 1'b0;
            default:                 two = 1'b1;
        endcase
        return two;
    endfunction

    // Left-rotate one 28-bit half by 1 or 2 bits.
    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        logic [27:0] r;
        if (two) begin
            r = {x[25:0], x[27:26]};
        end else begin
            r = {x[26:0], x[27]};
        end
        return r;
    endfunction

    // Left-rotate both halves of the {C,D} state.
    function automatic logic [55:0] rotl_cd(input logic [55:0] k, input logic two);
        return {rotl28(k[55:28], two), rotl28(k[27:0], two)};
    endfunction

`ifdef DES_KEY_SCHED_DECRYPT_EN
    // Right-rotate one 28-bit half by 1 or 2 bits.
    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        logic [27:0] r;
        if (two) begin
            r = {x[1:0], x[27:2]};
        end else begin
            r = {x[0], x[27:1]};
        end
        return r;
    endfunction

    // Right-rotate both halves of the {C,D} state.
    function automatic logic [55:0] rotr_cd(input logic [55:0] k, input logic two);
        return {rotr28(k[55:28], two), rotr28(k[27:0], two)};
    endfunction
`endif

    // Next-state logic: start in IDLE, advance one round per accepted subkey.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef DES_KEY_SCHED_DECRYPT_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start_i) begin
                    state_d = ST_RUN;
                    round_d = 4'd0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef DES_KEY_SCHED_DECRYPT_EN
                    dec_d   = decrypt_i;
                    // Decrypt round 1 uses the key unrotated.
                    if (decrypt_i) begin
                        key_d = key_i;
                    end else begin
                        key_d = rotl_cd(key_i, shift_is_two(4'd0));
                    end
`else
                    key_d   = rotl_cd(key_i, shift_is_two(4'd0));
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (valid_q && subkey_ready_i) begin
                    if (round_q == 4'd15) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q + 4'd1;
`ifdef DES_KEY_SCHED_DECRYPT_EN
                        // Decrypt walks the shift table backwards.
                        if (dec_q) begin
                            key_d = rotr_cd(key_q, shift_is_two(4'd15 - round_q));
                        end else begin
                            key_d = rotl_cd(key_q, shift_is_two(round_q + 4'd1));
                        end
`else
                        key_d = rotl_cd(key_q, shift_is_two(round_q + 4'd1));
`endif
                    end
                end else begin
                    // No transfer: hold the presented subkey.
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= 56'd0;
            round_q <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DES_KEY_SCHED_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DES_KEY_SCHED_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    assign subkey_valid_o = valid_q;
    assign key_o          = key_q;
    assign round_o        = round_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Self-checking bench for des_key_sched_ctrl.
// Expected subkeys come from cumulative rotation amounts over the shift table.
module tb_des_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        decrypt_i;
    logic [55:0] key_i;
    logic        subkey_ready_i;
    logic        subkey_valid_o;
    logic [55:0] key_o;
    logic [3:0]  round_o;
    logic        busy_o;
    logic        done_o;

    int n_vectors     = 0;
    int n_miscompares = 0;

    int s_tab [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_sched_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .decrypt_i      (decrypt_i),
        .key_i          (key_i),
        .subkey_ready_i (subkey_ready_i),
        .subkey_valid_o (subkey_valid_o),
        .key_o          (key_o),
        .round_o        (round_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Rotate a 28-bit half left by n (0..27).
    function automatic logic [27:0] rot28(input logic [27:0] x, input int n);
        logic [55:0] w;
        w = {28'd0, x};
        w = (w << n) | (w >> (28 - n));
        return w[27:0];
    endfunction

    // Reference subkey state for 0-based round r.
    function automatic logic [55:0] model_key(input logic [55:0] k, input bit dec, input int r);
        int amt;
        amt = 0;
        if (!dec) begin
            for (int j = 1; j <= r + 1; j++) amt += s_tab[j];
        end else begin
            for (int j = 2; j <= r + 1; j++) amt -= s_tab[18 - j];
        end
        amt = ((amt % 28) + 28) % 28;
        return {rot28(k[55:28], amt), rot28(k[27:0], amt)};
    endfunction

    function automatic bit eff_dec(input bit dec);
`ifdef DES_KEY_SCHED_DECRYPT_EN
        return dec;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_idle(input string tag);
        check_val({tag, "_valid"}, {63'd0, subkey_valid_o}, 64'd0);
        check_val({tag, "_busy"},  {63'd0, busy_o},         64'd0);
        check_val({tag, "_done"},  {63'd0, done_o},         64'd0);
    endtask

    // One idle cycle after a done pulse: done must have dropped.
    task automatic idle_cycle();
        start_i = 1'b0;
        @(negedge clk);
        check_idle("idle");
    endtask

    // Run a schedule starting at the current negedge.
    // mode: 0 = ready always 1, 1 = random ready, 2 = 5-cycle stall at round 3.
    // Returns at the done_o cycle (or after an abort) with start_i low.
    task automatic run_sched(input logic [55:0] k, input bit dec, input int mode,
                             input bit abort7, input bit lit_chk);
        int    r;
        int    cycles;
        int    stall;
        bit    d;
        bit    aborted;
        logic [55:0] lit [0:15];
        d       = eff_dec(dec);
        r       = 0;
        cycles  = 0;
        stall   = 0;
        aborted = 1'b0;
        if (d) begin
            lit[0]  = 56'h0000001_0000001;
            lit[1]  = 56'h8000000_8000000;
            lit[15] = 56'h0000002_0000002;
        end else begin
            lit[0]  = 56'h0000002_0000002;
            lit[1]  = 56'h0000004_0000004;
            lit[15] = 56'h0000001_0000001;
        end
        lit[2] = 56'h0000010_0000010;
        start_i   = 1'b1;
        key_i     = k;
        decrypt_i = dec;
        subkey_ready_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        while (r < 16 && cycles < 300 && !aborted) begin
            check_val("valid", {63'd0, subkey_valid_o}, 64'd1);
            check_val("busy",  {63'd0, busy_o},         64'd1);
            check_val("done",  {63'd0, done_o},         64'd0);
            check_val("round", {60'd0, round_o},        r[63:0]);
            check_val("key",   {8'd0, key_o},           {8'd0, model_key(k, d, r)});
            if (lit_chk && (r == 0 || r == 1 || r == 15 || (r == 2 && !d)))
                check_val("key_lit", {8'd0, key_o}, {8'd0, lit[r]});
            if (abort7 && r == 7) begin
                rst     = 1'b1;
                start_i = 1'b1;
                @(negedge clk);
                check_idle("rst_abort");
                check_val("rst_round", {60'd0, round_o}, 64'd0);
                check_val("rst_key",   {8'd0, key_o},    64'd0);
                rst     = 1'b0;
                start_i = 1'b0;
                @(negedge clk);
                check_idle("post_abort");
                aborted = 1'b1;
            end else begin
                case (mode)
                    0:       subkey_ready_i = 1'b1;
                    2: begin
                        if (r == 3 && stall < 5) begin
                            subkey_ready_i = 1'b0;
                            stall++;
                        end else begin
                            subkey_ready_i = 1'b1;
                        end
                    end
                    default: subkey_ready_i = $urandom_range(0, 1) == 1;
                endcase
                // Disturb start/key/direction while running; must be ignored.
                start_i   = $urandom_range(0, 3) == 0;
                key_i     = {$urandom, $urandom};
                decrypt_i = $urandom_range(0, 1) == 1;
                @(negedge clk);
                if (subkey_ready_i) r++;
                cycles++;
            end
        end
        start_i        = 1'b0;
        subkey_ready_i = 1'b0;
        if (!aborted) begin
            if (cycles >= 300) check_val("timeout", r[63:0], 64'd16);
            if (mode == 2) check_val("stall_cnt", stall[63:0], 64'd5);
            check_val("done_pulse", {63'd0, done_o},         64'd1);
            check_val("end_valid",  {63'd0, subkey_valid_o}, 64'd0);
            check_val("end_busy",   {63'd0, busy_o},         64'd0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        start_i        = 1'b1;
        decrypt_i      = 1'b0;
        key_i          = 56'h0;
        subkey_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        check_val("reset_round", {60'd0, round_o}, 64'd0);
        check_val("reset_key",   {8'd0, key_o},    64'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check_idle("after_reset");

        // Directed encrypt with known key, full throughput.
        run_sched(56'h0000001_0000001, 1'b0, 0, 1'b0, 1'b1);
        idle_cycle();
        // Same key with decrypt requested (encrypt if the macro is off).
        run_sched(56'h0000001_0000001, 1'b1, 0, 1'b0, 1'b1);
        idle_cycle();
        // Ready stall at round 3.
        run_sched({$urandom, $urandom}, 1'b0, 2, 1'b0, 1'b0);
        // Back-to-back: start in the done cycle.
        run_sched({$urandom, $urandom}, 1'b0, 0, 1'b0, 1'b0);
        run_sched({$urandom, $urandom}, 1'b1, 1, 1'b0, 1'b0);
        idle_cycle();
        // Reset at round 7, then a fresh run.
        run_sched({$urandom, $urandom}, 1'b0, 0, 1'b1, 1'b0);
        run_sched({$urandom, $urandom}, 1'b0, 0, 1'b0, 1'b0);
        idle_cycle();

        // Randomized runs.
        for (int i = 0; i < 24; i++) begin
            run_sched({$urandom, $urandom}, $urandom_range(0, 1) == 1,
                      1, 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/des_key_sched_ctrl.md
DES_KEY_SCHED_CTRL -- requirements
Module: des_key_sched_ctrl

Interface
REQ-001 SHALL have one clock domain and a synchronous, active-high reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start_i  input  1  start request; sampled only in IDLE.
REQ-005 decrypt_i  input  1  direction, sampled with start_i; 1 = decrypt schedule.
REQ-006 key_i  input  56  PC-1-permuted key, sampled with start_i; C = key_i[55:28], D = key_i[27:0].
REQ-007 subkey_ready_i  input  1  downstream round stage accepts current subkey state.
REQ-008 subkey_valid_o  output  1  key_o/round_o valid.
REQ-009 key_o  output  56  current {C,D} state for round round_o (fed to PC-2 downstream).
REQ-010 round_o  output  4  round index 0..15 (round 1 = 0).
REQ-011 busy_o  output  1  high in RUN.
REQ-012 done_o  output  1  one-cycle pulse after round 16 accepted.

Function
REQ-013 SHALL implement states IDLE and RUN; reset state IDLE.
REQ-014 IDLE: start_i=1 at edge T -> RUN at T+1 with round_o=0, subkey_valid_o=1, key_o = round-1 state derived from key_i.
REQ-015 start_i in RUN SHALL be ignored; key_i/decrypt_i SHALL NOT affect an in-progress schedule.
REQ-016 Transfer = subkey_valid_o & subkey_ready_i; without transfer, key_o/round_o/valid SHALL hold (no drop, no advance).
REQ-017 Transfer on round_o<15 -> next cycle round_o+1, key_o = next-round state, valid stays 1 (one subkey per cycle at full throughput).
REQ-018 Transfer on round_o=15 -> next cycle IDLE, subkey_valid_o=0, busy_o=0, done_o=1 for exactly one cycle.
REQ-019 A start_i in the done_o cycle SHALL be accepted (back-to-back keys, no bubble beyond that cycle).
REQ-020 Shift table s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; C and D rotate independently as 28-bit values.
REQ-021 Encrypt: round r state = rotl(state r-1, s[r]), state 0 = key_i.
REQ-022 Decrypt: round 1 state = key_i unrotated; round r>=2 state = rotr(state r-1, s[18-r]).
REQ-023 After 16 encrypt rounds cumulative rotation = 28, i.e. round-16 state equals key_i.

Reset
REQ-024 On rst=1 at an edge: state IDLE, subkey_valid_o=0, busy_o=0, done_o=0, round_o=0, key_o=0, latched direction=0.
REQ-025 rst mid-schedule SHALL abort immediately; no done_o; start_i same cycle as rst SHALL be ignored.

Configuration
REQ-026 Macro DES_KEY_SCHED_DECRYPT_EN: defined -> REQ-022 decrypt schedule supported.
REQ-027 Undefined -> decrypt_i ignored, right-rotate logic absent, every schedule runs per REQ-021.

Verification
REQ-028 key_i=56'h0000001_0000001, encrypt, ready=1 -> rounds 0,1,2 key_o = 0000002_0000002, 0000004_0000004, 0000010_0000010; done_o one cycle after round 15; round-15 key_o = key_i.
REQ-029 Same key, decrypt (macro defined) -> round 0 key_o = 0000001_0000001, round 1 = 8000000_8000000, round 15 key_o = rotl(key_i,1) = 0000002_0000002.
REQ-030 subkey_ready_i held 0 for 5 cycles at round 3 -> round_o=3, key_o stable, valid=1 throughout; resumes at round 4 after ready.
REQ-031 start_i pulsed in RUN with different key -> ignored, original 16 subkeys unchanged; start_i in done_o cycle -> new run begins next cycle.
REQ-032 rst asserted at round 7 -> next cycle all outputs at REQ-024 values, no done_o; fresh start completes normally.
REQ-033 Macro undefined, decrypt_i=1 -> output sequence identical to REQ-028.
